// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch handshake between the fetch stage and instruction memory.
// The fetch stage is the master: it drives the request and address, memory returns ready/data.
interface fetch_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_data
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC and the IF/ID register, with a one-word hold
// buffer that parks a fetched word while decode stalls.
//
// state   | meaning
// --------+---------------------------------------------------------------
// FETCH   | requesting imem at pc; consume the word when imem_ready=1
// HOLD    | word parked in the hold buffer, waiting for stall to drop
// HALTED  | HLT reached; everything frozen until rst
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          next_pc,
    input  logic                 redirect,
    input  logic [15:0]          redirect_pc,
    input  logic                 stall,
    input  logic                 halt,
    fetch_stage_if.master        imem,
    output logic [15:0]          pc,
    output logic [15:0]          if_id_instr,
    output logic [15:0]          if_id_pc,
    output logic [15:0]          if_id_pc2,
    output logic                 if_id_valid,
    output logic                 halted
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] ipc_q, ipc_d;
    logic [15:0] ipc2_q, ipc2_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic [15:0] hold_instr_q, hold_instr_d;
    logic [15:0] hold_pc_q, hold_pc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            ipc_q        <= 16'h0000;
            ipc2_q       <= 16'h0000;
            valid_q      <= 1'b0;
            halted_q     <= 1'b0;
            hold_instr_q <= 16'h0000;
            hold_pc_q    <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            ipc_q        <= ipc_d;
            ipc2_q       <= ipc2_d;
            valid_q      <= valid_d;
            halted_q     <= halted_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        ipc_d        = ipc_q;
        ipc2_d       = ipc2_q;
        valid_d      = valid_q;
        halted_d     = halted_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;

        if (state_q != S_HALTED) begin
            if (halt) begin
                state_d      = S_HALTED;
                halted_d     = 1'b1;
                valid_d      = 1'b0;
                instr_d      = NOP_INSTR;
                hold_instr_d = 16'h0000;
                hold_pc_d    = 16'h0000;
            end else if (redirect) begin
                // Late-resolved branch: any word arriving this cycle belongs to the wrong path.
                state_d      = S_FETCH;
                pc_d         = redirect_pc;
                valid_d      = 1'b0;
                instr_d      = NOP_INSTR;
                hold_instr_d = 16'h0000;
                hold_pc_d    = 16'h0000;
            end else if (state_q == S_FETCH) begin
                if (imem.imem_ready && !stall) begin
                    instr_d = imem.imem_data;
                    ipc_d   = pc_q;
                    ipc2_d  = pc_q + 16'd2;
                    valid_d = 1'b1;
                    pc_d    = next_pc;
                end else if (imem.imem_ready) begin
                    hold_instr_d = imem.imem_data;
                    hold_pc_d    = pc_q;
                    state_d      = S_HOLD;
                end else if (!stall) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end
            end else if (!stall) begin
                // pc still equals hold_pc here, so next_pc is the successor of the parked word.
                instr_d = hold_instr_q;
                ipc_d   = hold_pc_q;
                ipc2_d  = hold_pc_q + 16'd2;
                valid_d = 1'b1;
                pc_d    = next_pc;
                state_d = S_FETCH;
            end
        end
    end

    assign imem.imem_req  = (state_q == S_FETCH);
    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc       = ipc_q;
    assign if_id_pc2      = ipc2_q;
    assign if_id_valid    = valid_q;
    assign halted         = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver queues each expected IF/ID load,
// a negedge monitor pops and compares whenever a new valid IF/ID entry appears.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [15:0] next_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        stall;
    logic        halt;
    logic [15:0] pc;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_pc2;
    logic        if_id_valid;
    logic        halted;

    fetch_stage_if ifc ();

    fetch_stage #(
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .next_pc     (next_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .halt        (halt),
        .imem        (ifc.master),
        .pc          (pc),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_pc2   (if_id_pc2),
        .if_id_valid (if_id_valid),
        .halted      (halted)
    );

    // Memory returns addr ^ A5A5; PC control is plain sequential.
    assign ifc.imem_data = ifc.imem_addr ^ 16'hA5A5;
    assign next_pc       = pc + 16'd2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] ipc;
        logic [15:0] instr;
        logic [15:0] ipc2;
    } entry_t;

    entry_t exp_q[$];
    int     total = 0;
    int     bad   = 0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic push_fetch(input logic [15:0] fpc);
        entry_t e;
        e.ipc   = fpc;
        e.instr = fpc ^ 16'hA5A5;
        e.ipc2  = fpc + 16'd2;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a new presentation is a valid IF/ID whose contents changed or that just became valid.
    logic        prev_valid = 1'b0;
    logic [15:0] prev_pc    = 16'h0000;
    logic [15:0] prev_instr = 16'h0000;
    always @(negedge clk) begin
        if (!rst && if_id_valid &&
            (!prev_valid || if_id_pc != prev_pc || if_id_instr != prev_instr)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ifid: got pc=%h instr=%h expected none", if_id_pc, if_id_instr);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                chk("sb_if_id_pc", if_id_pc, e.ipc);
                chk("sb_if_id_instr", if_id_instr, e.instr);
                chk("sb_if_id_pc2", if_id_pc2, e.ipc2);
            end
        end
        prev_valid = if_id_valid;
        prev_pc    = if_id_pc;
        prev_instr = if_id_instr;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = 16'h0000;
        stall          = 1'b0;
        halt           = 1'b0;
        ifc.imem_ready = 1'b0;
        tick();
        tick();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_valid", {15'd0, if_id_valid}, 16'd0);
        chk("rst_instr", if_id_instr, 16'h0000);
        chk("rst_if_id_pc", if_id_pc, 16'h0000);
        chk("rst_if_id_pc2", if_id_pc2, 16'h0000);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_req", {15'd0, ifc.imem_req}, 16'd1);

        // zero-wait stream
        rst            = 1'b0;
        ifc.imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_fetch(16'(2 * i));
            tick();
        end
        chk("zw_if_id_pc", if_id_pc, 16'h0004);
        chk("zw_instr", if_id_instr, 16'hA5A1);
        chk("zw_pc2", if_id_pc2, 16'h0006);
        chk("zw_valid", {15'd0, if_id_valid}, 16'd1);
        chk("zw_pc", pc, 16'h0006);

        // wait states at 0x0010
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        tick();
        redirect       = 1'b0;
        ifc.imem_ready = 1'b0;
        chk("ws_redirect_pc", pc, 16'h0010);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("ws_req", {15'd0, ifc.imem_req}, 16'd1);
            chk("ws_addr", ifc.imem_addr, 16'h0010);
            chk("ws_valid", {15'd0, if_id_valid}, 16'd0);
        end
        ifc.imem_ready = 1'b1;
        push_fetch(16'h0010);
        tick();
        chk("ws_load_pc", if_id_pc, 16'h0010);
        chk("ws_next_pc", pc, 16'h0012);

        // stall while ready at 0x0020, with 0x001E already in IF/ID
        redirect    = 1'b1;
        redirect_pc = 16'h001E;
        tick();
        redirect = 1'b0;
        push_fetch(16'h001E);
        tick();
        chk("st_pre_pc", pc, 16'h0020);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_req", {15'd0, ifc.imem_req}, 16'd0);
            chk("st_hold_ifid", if_id_pc, 16'h001E);
            chk("st_hold_valid", {15'd0, if_id_valid}, 16'd1);
            chk("st_hold_pc", pc, 16'h0020);
        end
        stall = 1'b0;
        push_fetch(16'h0020);
        tick();
        ifc.imem_ready = 1'b0;
        chk("st_rel_instr", if_id_instr, 16'hA585);
        chk("st_rel_pc", pc, 16'h0022);
        chk("st_rel_req", {15'd0, ifc.imem_req}, 16'd1);

        // redirect while in HOLD
        ifc.imem_ready = 1'b1;
        stall          = 1'b1;
        tick();
        chk("rh_in_hold_req", {15'd0, ifc.imem_req}, 16'd0);
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        chk("rh_pc", pc, 16'h0100);
        chk("rh_valid", {15'd0, if_id_valid}, 16'd0);
        chk("rh_instr", if_id_instr, 16'h0000);
        chk("rh_req", {15'd0, ifc.imem_req}, 16'd1);
        redirect       = 1'b0;
        stall          = 1'b0;
        ifc.imem_ready = 1'b0;
        tick();
        chk("rh_no_leak_valid", {15'd0, if_id_valid}, 16'd0);
        chk("rh_no_leak_instr", if_id_instr, 16'h0000);

        // PC+2 wrap
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        redirect       = 1'b0;
        ifc.imem_ready = 1'b1;
        push_fetch(16'hFFFE);
        tick();
        chk("wrap_pc2", if_id_pc2, 16'h0000);
        chk("wrap_pc", pc, 16'h0000);
        push_fetch(16'h0000);
        tick();
        ifc.imem_ready = 1'b0;
        chk("wrap_next_pc", pc, 16'h0002);

        // halt together with redirect
        halt        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0300;
        tick();
        halt     = 1'b0;
        redirect = 1'b0;
        chk("halt_halted", {15'd0, halted}, 16'd1);
        chk("halt_pc", pc, 16'h0002);
        chk("halt_req", {15'd0, ifc.imem_req}, 16'd0);
        chk("halt_valid", {15'd0, if_id_valid}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            ifc.imem_ready = 1'(i % 2 == 0);
            redirect       = 1'(i % 2 == 1);
            redirect_pc    = 16'h0400;
            tick();
            chk("halted_pc", pc, 16'h0002);
            chk("halted_req", {15'd0, ifc.imem_req}, 16'd0);
            chk("halted_sticky", {15'd0, halted}, 16'd1);
        end
        ifc.imem_ready = 1'b0;
        redirect       = 1'b0;
        rst            = 1'b1;
        tick();
        rst = 1'b0;
        chk("rerst_pc", pc, 16'h0000);
        chk("rerst_halted", {15'd0, halted}, 16'd0);
        chk("rerst_req", {15'd0, ifc.imem_req}, 16'd1);

        tick();
        tick();
        chk("sb_drained", 16'(exp_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
